osc_sequencer: RTL and testbench
================================

// Module: osc_sequencer
// PURPOSE
//  Controller for one 7-bit bounce oscillator (inputs en/reset/lower_bound/upper_bound, output coord).
//  Holds a table of NSEG segments {lo, hi, reps}. Steps the oscillator through them at a programmable tick rate.
//  Counts turnarounds via a shadow direction bit. Advances segments, optionally loops, and flags completion.
//  Sits between user/config logic and the oscillator instance in the animation path.
// PARAMETERS
//  NSEG  4   number of segment table entries (2..16); SW = $clog2(NSEG)
//  RW    8   width of per-segment turnaround count (reps)
// PORTS
//  clk        in   1    system clock
//  reset      in   1    synchronous, active-low reset
//  wr_en      in   1    table write strobe; ignored while busy=1
//  wr_addr    in   SW   table entry index
//  wr_lo      in   7    segment lower bound
//  wr_hi      in   7    segment upper bound
//  wr_reps    in   RW   turnarounds per segment; 0 treated as 1
//  wr_err     out  1    1-cycle pulse: write rejected (busy, or wr_lo > wr_hi)
//  seg_last   in   SW   index of last active segment; latched on start
//  tick_div   in   16   osc_en period minus 1; latched on start
//  loop_en    in   1    1: wrap to seg 0 after seg_last; latched on start
//  start      in   1    begin sequence from seg 0 (IDLE only)
//  stop       in   1    abort to IDLE
//  pause      in   1    freeze while high (RUN only)
//  coord      in   7    oscillator output
//  osc_en     out  1    oscillator en
//  osc_clr    out  1    oscillator reset (active-high clear)
//  osc_lo     out  7    oscillator lower_bound (registered)
//  osc_hi     out  7    oscillator upper_bound (registered)
//  seg_idx    out  SW   current segment
//  busy       out  1    state != IDLE
//  done       out  1    1-cycle pulse on sequence completion
// BEHAVIOUR
//  Reset (reset=0 at clk edge)
//   - state=IDLE; all outputs 0; prescaler, edge count, shadow dir (sdir) = 0.
//   - Table contents are unchanged. Reset overrides every other input, including mid-operation.
//  FSM states: IDLE, CLEAR, RUN, DONE
//   - IDLE -> CLEAR on start: latch seg_last/tick_div/loop_en; seg_idx<=0.
//   - CLEAR (1 cycle): osc_clr=1, osc_en=0; osc_lo/hi <= table[seg_idx]; sdir<=0, edge cnt<=0, prescaler<=0; -> RUN.
//   - RUN: when pause=0: if pcnt==tick_div then osc_en=1 and pcnt<=0, else pcnt<=pcnt+1.
//     pause=1: osc_en=0, pcnt holds.
//   - osc_en is combinational: (state==RUN) & ~pause & (pcnt==tick_div).
//  Edge detect, evaluated only in osc_en cycles, using the pre-edge coord:
//   - sdir=0 & coord>=osc_hi: sdir<=1, count an edge.
//   - sdir=1 & coord<=osc_lo: sdir<=0, count an edge.
//   - This mirrors the oscillator's 1-tick dwell at each bound.
//  Segment end (counted edge makes count == max(reps,1)):
//   - seg_idx<seg_last: seg_idx+1 -> CLEAR.
//   - seg_idx==seg_last & loop_en: seg_idx<=0 -> CLEAR.
//   - seg_idx==seg_last & ~loop_en: -> DONE.
//  DONE (1 cycle): done=1 -> IDLE. osc_lo/hi and seg_idx hold their last values.
//  stop=1 in CLEAR/RUN/DONE: -> IDLE next cycle; osc_en=0 in the stop cycle; no clear; no done pulse.
//  Priority: reset > stop > segment end > pause.
//   - start is ignored when busy; pause is ignored outside RUN.
//  Table writes accepted only in IDLE with wr_lo<=wr_hi. Writes and start in the same cycle: the write lands; start uses the new table.
//  seg_last > NSEG-1 is clamped to NSEG-1 at latch. Bounds are 7-bit unsigned; no arithmetic wrap is possible.
// TESTING
//  1. seg0={2,5,2}, seg_last=0, tick_div=0, loop_en=0, start
//     -> osc_clr 1 cycle, then osc_en every cycle; coord 0..5; edge at coord 5 then at 2; done 1 cycle after the coord=2 osc_en; busy=0.
//  2. tick_div=3, same table -> osc_en high exactly 1 of every 4 RUN cycles; first pulse on the 4th RUN cycle.
//  3. seg0={2,5,1}, seg1={10,12,1}, seg_last=1, loop_en=1
//     -> seg_idx 0,1,0,...; osc_clr at each change; osc_lo/hi = 2/5 then 10/12; done never asserts.
//  4. pause=1 for 10 cycles mid-RUN -> osc_en=0, coord and pcnt frozen; resumes at the same phase.
//     stop mid-RUN -> busy=0 next cycle, no done.
//  5. Drive reset=0 mid-RUN -> all outputs 0 next cycle.
//     A subsequent start replays seg0 with the table intact.
//  6. Write wr_lo=9, wr_hi=3 -> wr_err pulse, entry unchanged.
//     Write while busy -> wr_err pulse, no change.

Source files
------------

// File: rtl/osc_sequencer_if.sv
// Bundle of config, table-write and oscillator-side signals for osc_sequencer.
// The sequencer takes the slave modport; the user/config side takes master.
interface osc_sequencer_if #(
  parameter int NSEG = 4,
  parameter int RW   = 8
);
  localparam int SW = (NSEG > 1) ? $clog2(NSEG) : 1;

  logic          wr_en;
  logic [SW-1:0] wr_addr;
  logic [6:0]    wr_lo;
  logic [6:0]    wr_hi;
  logic [RW-1:0] wr_reps;
  logic          wr_err;
  logic [SW-1:0] seg_last;
  logic [15:0]   tick_div;
  logic          loop_en;
  logic          start;
  logic          stop;
  logic          pause;
  logic [6:0]    coord;
  logic          osc_en;
  logic          osc_clr;
  logic [6:0]    osc_lo;
  logic [6:0]    osc_hi;
  logic [SW-1:0] seg_idx;
  logic          busy;
  logic          done;

  modport master (
    output wr_en, wr_addr, wr_lo, wr_hi, wr_reps,
    output seg_last, tick_div, loop_en, start, stop, pause, coord,
    input  wr_err, osc_en, osc_clr, osc_lo, osc_hi, seg_idx, busy, done
  );

  modport slave (
    input  wr_en, wr_addr, wr_lo, wr_hi, wr_reps,
    input  seg_last, tick_div, loop_en, start, stop, pause, coord,
    output wr_err, osc_en, osc_clr, osc_lo, osc_hi, seg_idx, busy, done
  );
endinterface

// File: rtl/osc_sequencer.sv
// Segment-table sequencer for a 7-bit bounce oscillator: steps through {lo,hi,reps}
// segments at a programmable tick rate, counting turnarounds with a shadow direction bit.
module osc_sequencer #(
  parameter int NSEG = 4,
  parameter int RW   = 8
) (
  input  logic           clk,
  input  logic           reset,
  osc_sequencer_if.slave bus
);
  localparam int SW = (NSEG > 1) ? $clog2(NSEG) : 1;

  typedef enum logic [1:0] {IDLE, CLEAR, RUN, DONE} state_t;

  state_t        state;
  logic [6:0]    tbl_lo   [NSEG];
  logic [6:0]    tbl_hi   [NSEG];
  logic [RW-1:0] tbl_reps [NSEG];

  logic [SW-1:0] seg_last_q;
  logic [SW-1:0] seg_idx_q;
  logic [SW-1:0] seg_last_clamp;
  logic [15:0]   tick_div_q;
  logic [15:0]   pcnt;
  logic          loop_q;
  logic          sdir;
  logic [RW-1:0] ecnt;
  logic          wr_err_q;
  logic [6:0]    osc_lo_q;
  logic [6:0]    osc_hi_q;

  logic wr_ok;
  logic osc_en_c;
  logic edge_hit;
  logic seg_end;

  assign wr_ok = bus.wr_en & (state == IDLE) & (bus.wr_lo <= bus.wr_hi);
  assign seg_last_clamp = (32'(bus.seg_last) > 32'(NSEG - 1)) ? SW'(NSEG - 1) : bus.seg_last;

  // Stop wins over a pending tick, so the oscillator never steps in the abort cycle.
  assign osc_en_c = (state == RUN) & ~bus.pause & ~bus.stop & (pcnt == tick_div_q);
  assign edge_hit = osc_en_c & (sdir ? (bus.coord <= osc_lo_q) : (bus.coord >= osc_hi_q));
  assign seg_end  = edge_hit & ((ecnt + RW'(1)) == tbl_reps[seg_idx_q]);

  // Table storage holds its contents through reset; reps of 0 is stored as 1.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      tbl_lo[bus.wr_addr]   <= bus.wr_lo;
      tbl_hi[bus.wr_addr]   <= bus.wr_hi;
      tbl_reps[bus.wr_addr] <= (bus.wr_reps == '0) ? RW'(1) : bus.wr_reps;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      seg_last_q <= '0;
      seg_idx_q  <= '0;
      tick_div_q <= '0;
      pcnt       <= '0;
      loop_q     <= 1'b0;
      sdir       <= 1'b0;
      ecnt       <= '0;
      wr_err_q   <= 1'b0;
      osc_lo_q   <= '0;
      osc_hi_q   <= '0;
    end else begin
      wr_err_q <= bus.wr_en & ~wr_ok;
      case (state)
        IDLE: begin
          if (bus.start) begin
            seg_last_q <= seg_last_clamp;
            tick_div_q <= bus.tick_div;
            loop_q     <= bus.loop_en;
            seg_idx_q  <= '0;
            state      <= CLEAR;
          end
        end
        CLEAR: begin
          if (bus.stop) begin
            state <= IDLE;
          end else begin
            osc_lo_q <= tbl_lo[seg_idx_q];
            osc_hi_q <= tbl_hi[seg_idx_q];
            sdir     <= 1'b0;
            ecnt     <= '0;
            pcnt     <= '0;
            state    <= RUN;
          end
        end
        RUN: begin
          if (bus.stop) begin
            state <= IDLE;
          end else if (seg_end) begin
            if (seg_idx_q != seg_last_q) begin
              seg_idx_q <= seg_idx_q + SW'(1);
              state     <= CLEAR;
            end else if (loop_q) begin
              seg_idx_q <= '0;
              state     <= CLEAR;
            end else begin
              state <= DONE;
            end
          end else if (!bus.pause) begin
            pcnt <= osc_en_c ? 16'd0 : pcnt + 16'd1;
            if (edge_hit) begin
              sdir <= ~sdir;
              ecnt <= ecnt + RW'(1);
            end
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.osc_en  = osc_en_c;
  assign bus.osc_clr = (state == CLEAR) & ~bus.stop;
  assign bus.done    = (state == DONE) & ~bus.stop;
  assign bus.busy    = (state != IDLE);
  assign bus.osc_lo  = osc_lo_q;
  assign bus.osc_hi  = osc_hi_q;
  assign bus.seg_idx = seg_idx_q;
  assign bus.wr_err  = wr_err_q;
endmodule

// File: tb/tb_osc_sequencer.sv
// Bench for osc_sequencer: bounce-oscillator model plus a segment timeline predicted
// from closed-form tick counts, under random tables, pause, stop and busy writes.
module tb_osc_sequencer;
  localparam int NSEG = 4;
  localparam int RW   = 8;
  localparam int SW   = 2;

  logic clk = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   m_lo   [NSEG];
  int   m_hi   [NSEG];
  int   m_reps [NSEG];
  logic odir;

  always #5 clk = ~clk;

  osc_sequencer_if #(.NSEG(NSEG), .RW(RW)) bus ();
  osc_sequencer #(.NSEG(NSEG), .RW(RW)) dut (.clk(clk), .reset(reset), .bus(bus));

  // Oscillator: one step per en, dwelling one tick at each bound while turning round.
  always @(posedge clk) begin
    if (!reset || bus.osc_clr) begin
      bus.coord <= 7'd0;
      odir      <= 1'b0;
    end else if (bus.osc_en) begin
      if (!odir) begin
        if (bus.coord >= bus.osc_hi) odir <= 1'b1;
        else bus.coord <= bus.coord + 7'd1;
      end else begin
        if (bus.coord <= bus.osc_lo) odir <= 1'b0;
        else bus.coord <= bus.coord - 7'd1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_reset_state();
    check("rst", {bus.busy, bus.osc_clr, bus.osc_en, bus.done, bus.wr_err,
                  bus.seg_idx, bus.osc_lo, bus.osc_hi}, 32'd0);
  endtask

  task automatic write_entry(input int a, input int lo, input int hi, input int reps);
    @(posedge clk); #1;
    bus.wr_en   = 1'b1;
    bus.wr_addr = SW'(a);
    bus.wr_lo   = 7'(lo);
    bus.wr_hi   = 7'(hi);
    bus.wr_reps = RW'(reps);
    if (lo <= hi) begin
      m_lo[a] = lo; m_hi[a] = hi; m_reps[a] = reps;
    end
    @(posedge clk); #1;
    bus.wr_en = 1'b0;
    @(negedge clk);
    check("wr_err", 32'(bus.wr_err), 32'(lo > hi));
  endtask

  // Segment k starts with one CLEAR cycle and then needs
  // (hi+1) + (reps-1)*(hi-lo+1) oscillator ticks, each tick_div+1 RUN cycles.
  task automatic run_seq(input int sl, input int td, input bit lp, input bit stop_rand,
                         input bit bw_en, input bit ws, input int pz_pct);
    int ss [17];
    int tper, nc, nrun, e_end, stop_at, m, j, seg, r, ticks, ph, s;
    int nlo, nhi, nreps;
    bit pz, stp, bw, wr_pend, en_t, fin;
    logic [6:0] exp;
    tper = td + 1; nc = sl + 1; nrun = lp ? 2 * nc : nc;
    nlo = 0; nhi = 0; nreps = 0;
    if (ws) begin
      nlo = $urandom_range(0, 20); nhi = nlo + $urandom_range(0, 10); nreps = $urandom_range(0, 3);
      m_lo[0] = nlo; m_hi[0] = nhi; m_reps[0] = nreps;
    end
    ss[0] = 0;
    for (int k = 0; k < nrun; k++) begin
      s = k % nc;
      r = (m_reps[s] == 0) ? 1 : m_reps[s];
      ticks = (m_hi[s] + 1) + (r - 1) * (m_hi[s] - m_lo[s] + 1);
      ss[k+1] = ss[k] + 1 + ticks * tper;
    end
    e_end = ss[nrun];
    stop_at = lp ? e_end : (stop_rand ? int'($urandom_range(1, e_end - 1)) : -1);

    @(posedge clk); #1;
    bus.seg_last = SW'(sl); bus.tick_div = 16'(td); bus.loop_en = lp; bus.start = 1'b1;
    if (ws) begin
      bus.wr_en = 1'b1; bus.wr_addr = '0;
      bus.wr_lo = 7'(nlo); bus.wr_hi = 7'(nhi); bus.wr_reps = RW'(nreps);
    end
    @(negedge clk);
    check("idle", 32'(bus.busy), 32'd0);
    @(posedge clk); #1;
    bus.start = 1'b0; bus.wr_en = 1'b0;

    m = 0; wr_pend = 1'b0; fin = 1'b0;
    for (int cyc = 0; cyc < 20000 && !fin; cyc++) begin
      stp = (m == stop_at);
      pz  = !stp && ($urandom_range(0, 99) < pz_pct);
      bw  = bw_en && (m == 3) && !stp && (e_end > 3) && (stop_at < 0 || stop_at > 3);
      bus.stop = stp; bus.pause = pz;
      if (bw) begin
        bus.wr_en = 1'b1; bus.wr_addr = SW'($urandom_range(0, NSEG - 1));
        bus.wr_lo = 7'd0; bus.wr_hi = 7'd1; bus.wr_reps = RW'(1);
      end
      en_t = 1'b0;
      if (m < e_end) begin
        j = 0;
        while (ss[j+1] <= m) j++;
        seg = j % nc;
        if (m == ss[j]) ph = 0;
        else begin
          ph = 1;
          en_t = ((m - ss[j]) % tper) == 0;
        end
      end else begin
        ph  = lp ? 0 : 2;
        seg = lp ? 0 : sl;
      end
      exp = {1'b1, (ph == 0) && !stp, (ph == 1) && en_t && !pz && !stp,
             (ph == 2) && !stp, wr_pend, SW'(seg)};
      @(negedge clk);
      check("ctl", 32'({bus.busy, bus.osc_clr, bus.osc_en, bus.done, bus.wr_err, bus.seg_idx}),
            32'(exp));
      if (ph != 0)
        check("bnd", 32'({bus.osc_lo, bus.osc_hi}), 32'({7'(m_lo[seg]), 7'(m_hi[seg])}));
      if (stp || ph == 2) fin = 1'b1;
      else if (!(pz && ph == 1)) m++;
      wr_pend = bw;
      @(posedge clk); #1;
      bus.wr_en = 1'b0; bus.stop = 1'b0; bus.pause = 1'b0;
    end
    if (!fin) check("timeout", 32'd0, 32'd1);
    @(negedge clk);
    check("end", 32'({bus.busy, bus.done, bus.wr_err}), 32'({2'b00, wr_pend}));
  endtask

  task automatic reset_midrun();
    @(posedge clk); #1;
    bus.seg_last = SW'(1); bus.tick_div = 16'd0; bus.loop_en = 1'b0; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (6) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check_reset_state();
  endtask

  initial begin
    reset = 1'b0;
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_lo = '0; bus.wr_hi = '0; bus.wr_reps = '0;
    bus.seg_last = '0; bus.tick_div = '0; bus.loop_en = 1'b0;
    bus.start = 1'b0; bus.stop = 1'b0; bus.pause = 1'b0;
    for (int i = 0; i < NSEG; i++) begin
      m_lo[i] = 0; m_hi[i] = 0; m_reps[i] = 0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_state();
    @(posedge clk); #1;
    reset = 1'b1;
    for (int i = 0; i < NSEG; i++) write_entry(i, 0, 3, 1);

    write_entry(0, 2, 5, 2);
    run_seq(0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    run_seq(0, 3, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    write_entry(0, 2, 5, 1);
    write_entry(1, 10, 12, 1);
    run_seq(1, 0, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    write_entry(0, 9, 3, 1);
    run_seq(1, 1, 1'b0, 1'b0, 1'b0, 1'b0, 30);
    run_seq(1, 1, 1'b0, 1'b1, 1'b1, 1'b0, 20);
    reset_midrun();
    run_seq(1, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    run_seq(2, 0, 1'b0, 1'b0, 1'b0, 1'b1, 0);

    for (int t = 0; t < 8; t++) begin
      for (int a = 0; a < NSEG; a++) begin
        int lo;
        lo = $urandom_range(0, 24);
        write_entry(a, lo, lo + $urandom_range(0, 7), $urandom_range(0, 3));
      end
      if ($urandom_range(0, 1) == 1)
        write_entry($urandom_range(0, NSEG - 1), 21 + $urandom_range(0, 100), 20, 1);
      run_seq($urandom_range(0, NSEG - 1), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              $urandom_range(0, 30));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
